// File: rtl/i2c_slave_rx_sequencer.sv
// Slave-side I2C receive sequencer: address decode, ACK requests, byte delivery.
// Define I2C_GENERAL_CALL_EN to also accept the general-call address 8'h00.
module i2c_slave_rx_sequencer #(
  parameter logic [6:0] SLV_ADDR  = 7'h50,
  parameter logic [7:0] MAX_BYTES = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       scl_i,
  output logic       rd_en,
  output logic       rd_is_byte,
  input  logic       rd_ld,
  input  logic       rd_data,
  input  logic       rd_get_start,
  input  logic       rd_get_stop,
  input  logic       rd_bus_err,
  input  logic       rd_finish,
  output logic       ack_req,
  output logic       ack_val,
  input  logic       ack_done,
  output logic       tx_req,
  input  logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       stop_o,
  output logic       err_o,
  output logic [7:0] byte_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    TX,
    WAIT_STOP
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] sr;
  logic       rw_q;
  logic       en_q;
  logic       in_rx;
  logic       quiet;
  logic       addr_hit;
  logic       overrun;
  logic       fin_addr;
  logic       fin_data;
  logic       accept;
  logic       enter_rx;
  logic [7:0] cnt_inc;

  assign in_rx = (state == ADDR) ||
                 (state == DATA);
  assign quiet = enable && !rd_get_stop &&
                 !rd_get_start && !rd_bus_err;

`ifdef I2C_GENERAL_CALL_EN
  assign addr_hit = (sr[7:1] == SLV_ADDR) ||
                    (sr == 8'h00);
`else
  assign addr_hit = (sr[7:1] == SLV_ADDR);
`endif

  assign overrun  = rx_valid && !rx_ready;
  assign fin_addr = quiet && rd_finish &&
                    (state == ADDR);
  assign fin_data = quiet && rd_finish &&
                    (state == DATA);
  assign accept   = fin_data && !overrun;
  assign cnt_inc  = (byte_cnt == 8'hFF) ?
                    8'hFF : byte_cnt + 8'd1;
  assign enter_rx = (state_nx != state) &&
                    ((state_nx == ADDR) ||
                     (state_nx == DATA));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else if (rd_get_stop) begin
      state_nx = IDLE;
    end else if (rd_get_start) begin
      state_nx = SYNC;
    end else if (rd_bus_err && in_rx) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        SYNC:
          if (!scl_i) state_nx = ADDR;
        ADDR:
          if (rd_finish)
            state_nx = addr_hit ?
                       ADDR_ACK : WAIT_STOP;
        ADDR_ACK:
          if (ack_done)
            state_nx = rw_q ? TX : DATA;
        DATA:
          if (rd_finish) state_nx = DATA_ACK;
        DATA_ACK:
          if (ack_done)
            state_nx = ack_val ?
                       WAIT_STOP : DATA;
        TX:
          if (tx_done) state_nx = WAIT_STOP;
        default:
          state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      sr       <= 8'h00;
      rw_q     <= 1'b0;
      ack_val  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      byte_cnt <= 8'h00;
      stop_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      en_q   <= enable;
      stop_o <= enable && rd_get_stop &&
                (state != IDLE) &&
                (state != WAIT_STOP);
      err_o  <= (quiet && (rd_bus_err || 1'b0)) ||
                (enable && !rd_get_stop &&
                 !rd_get_start && rd_bus_err &&
                 in_rx) ||
                (fin_data && overrun);

      if (enter_rx)   sr <= 8'h00;
      else if (rd_ld) sr <= {sr[6:0], rd_data};

      if (fin_addr && addr_hit) begin
        ack_val  <= 1'b0;
        rw_q     <= sr[0];
        byte_cnt <= 8'h00;
      end else if (fin_data) begin
        ack_val <= overrun ||
                   ((MAX_BYTES != 8'd0) &&
                    (cnt_inc == MAX_BYTES));
      end

      // A new byte wins over the handshake clearing the old one.
      if (accept) begin
        rx_data  <= sr;
        rx_valid <= 1'b1;
        byte_cnt <= cnt_inc;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_en = 1'b0;
    unique case (1'b1)
      state == IDLE:
        rd_en = en_q;
      state == ADDR,
      state == DATA,
      state == WAIT_STOP:
        rd_en = 1'b1;
      default:
        rd_en = 1'b0;
    endcase
  end

  assign rd_is_byte = 1'b1;
  assign ack_req    = (state == ADDR_ACK) ||
                      (state == DATA_ACK);
  assign tx_req     = (state == TX);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_i2c_slave_rx_sequencer.sv
// Bench for i2c_slave_rx_sequencer: two instances (MAX_BYTES 0 and 2) share
// one open-loop stimulus; table vectors, corner sequences, random transfers.
module tb_i2c_slave_rx_sequencer;

`ifdef I2C_GENERAL_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, enable, scl_i;
  logic rd_ld, rd_data;
  logic rd_get_start, rd_get_stop;
  logic rd_bus_err, rd_finish;
  logic ack_done, tx_done, rx_ready;

  logic [1:0] rd_en, rd_is_byte;
  logic [1:0] ack_req, ack_val, tx_req;
  logic [1:0] rx_valid, busy, stop_o, err_o;
  logic [7:0] rx_data  [2];
  logic [7:0] byte_cnt [2];

  int checks   = 0;
  int failures = 0;
  logic [7:0] last [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    i2c_slave_rx_sequencer #(
      .SLV_ADDR (7'h50),
      .MAX_BYTES(g == 1 ? 8'd2 : 8'd0)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .scl_i       (scl_i),
      .rd_en       (rd_en[g]),
      .rd_is_byte  (rd_is_byte[g]),
      .rd_ld       (rd_ld),
      .rd_data     (rd_data),
      .rd_get_start(rd_get_start),
      .rd_get_stop (rd_get_stop),
      .rd_bus_err  (rd_bus_err),
      .rd_finish   (rd_finish),
      .ack_req     (ack_req[g]),
      .ack_val     (ack_val[g]),
      .ack_done    (ack_done),
      .tx_req      (tx_req[g]),
      .tx_done     (tx_done),
      .rx_data     (rx_data[g]),
      .rx_valid    (rx_valid[g]),
      .rx_ready    (rx_ready),
      .busy        (busy[g]),
      .stop_o      (stop_o[g]),
      .err_o       (err_o[g]),
      .byte_cnt    (byte_cnt[g])
    );
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         r0;
    bit         r1;
    bit         a_ack;
    bit         n1;
    logic [7:0] q1;
    logic [7:0] cnt;
    bit         err;
    bit         stp;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_rd_en"},    rd_en[m],      0);
      chk({tag, "_is_byte"},  rd_is_byte[m], 1);
      chk({tag, "_ack_req"},  ack_req[m],    0);
      chk({tag, "_ack_val"},  ack_val[m],    0);
      chk({tag, "_tx_req"},   tx_req[m],     0);
      chk({tag, "_rx_data"},  rx_data[m],    0);
      chk({tag, "_rx_valid"}, rx_valid[m],   0);
      chk({tag, "_busy"},     busy[m],       0);
      chk({tag, "_stop_o"},   stop_o[m],     0);
      chk({tag, "_err_o"},    err_o[m],      0);
      chk({tag, "_byte_cnt"}, byte_cnt[m],   0);
    end
  endtask

  task automatic do_start();
    rx_ready     = 1'b1;
    scl_i        = 1'b1;
    rd_get_start = 1'b1;
    tick();
    rd_get_start = 1'b0;
    tick();
    scl_i = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      rd_ld   = 1'b1;
      rd_data = b[i];
      tick();
    end
    rd_ld     = 1'b0;
    rd_data   = 1'b0;
    rd_finish = 1'b1;
    tick();
    rd_finish = 1'b0;
  endtask

  task automatic ack_pulse();
    tick();
    ack_done = 1'b1;
    tick();
    ack_done = 1'b0;
  endtask

  task automatic do_stop();
    rd_get_stop = 1'b1;
    tick();
    rd_get_stop = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    do_start();
    send_byte(v.addr);
    chk($sformatf("v%0d_addr_ack", i),
        ack_req[0], v.a_ack);
    ack_pulse();
    rx_ready = v.r0;
    send_byte(v.d0);
    if (v.a_ack) begin
      chk($sformatf("v%0d_b0_ack", i),
          ack_req[0], 1);
      chk($sformatf("v%0d_b0_val", i),
          ack_val[0], 0);
      chk($sformatf("v%0d_b0_data", i),
          rx_data[0], v.d0);
    end else begin
      chk($sformatf("v%0d_b0_noack", i),
          ack_req[0], 0);
    end
    ack_pulse();
    rx_ready = v.r1;
    send_byte(v.d1);
    if (v.a_ack) begin
      chk($sformatf("v%0d_b1_val", i),
          ack_val[0], v.n1);
      chk($sformatf("v%0d_b1_err", i),
          err_o[0], v.err);
      chk($sformatf("v%0d_b1_data", i),
          rx_data[0], v.q1);
      chk($sformatf("v%0d_b1_cnt", i),
          byte_cnt[0], v.cnt);
    end else begin
      chk($sformatf("v%0d_b1_noack", i),
          ack_req[0], 0);
    end
    ack_pulse();
    if (!v.a_ack) begin
      rd_bus_err = 1'b1;
      tick();
      rd_bus_err = 1'b0;
      chk($sformatf("v%0d_ws_err", i),
          err_o[0], 0);
    end
    chk($sformatf("v%0d_busy", i), busy[0], 1);
    do_stop();
    chk($sformatf("v%0d_stop_o", i),
        stop_o[0], v.stp);
    chk($sformatf("v%0d_idle", i), busy[0], 0);
    rx_ready = 1'b1;
    cyc(2);
  endtask

  task automatic rand_xfer(input int t);
    logic [7:0] addr;
    logic [7:0] d;
    int  sel, n, mx;
    bit  hit, ov, r, nk;
    bit  act  [2];
    bit  held [2];
    int  cnt  [2];
    sel = $urandom_range(0, 4);
    case (sel)
      0:       addr = 8'hA0;
      1:       addr = 8'hA1;
      2:       addr = 8'hA2;
      3:       addr = 8'h00;
      default: addr = 8'($urandom_range(0, 255));
    endcase
    hit = (addr[7:1] == 7'h50) ||
          (GC && addr == 8'h00);
    do_start();
    send_byte(addr);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("r%0d_addr%0d", t, m),
          ack_req[m], hit);
      act[m]  = hit && !addr[0];
      held[m] = 1'b0;
      cnt[m]  = 0;
    end
    ack_pulse();
    if (hit && addr[0]) begin
      chk($sformatf("r%0d_tx_on", t), tx_req, 2'b11);
      cyc($urandom_range(0, 3));
      chk($sformatf("r%0d_tx_hold", t), tx_req, 2'b11);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk($sformatf("r%0d_tx_off", t), tx_req, 2'b00);
      chk($sformatf("r%0d_tx_busy", t), busy, 2'b11);
    end else begin
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        r = 1'($urandom_range(0, 1));
        rx_ready = r;
        d = 8'($urandom_range(0, 255));
        send_byte(d);
        for (int m = 0; m < 2; m++) begin
          mx = (m == 1) ? 2 : 0;
          if (act[m]) begin
            ov = held[m] && !r;
            if (!ov) begin
              if (cnt[m] < 255) cnt[m]++;
              last[m] = d;
              held[m] = 1'b1;
            end
            nk = ov || (mx != 0 && cnt[m] == mx);
            chk($sformatf("r%0d_b%0d_req%0d", t, k, m),
                ack_req[m], 1);
            chk($sformatf("r%0d_b%0d_val%0d", t, k, m),
                ack_val[m], nk);
            chk($sformatf("r%0d_b%0d_err%0d", t, k, m),
                err_o[m], ov);
            chk($sformatf("r%0d_b%0d_vld%0d", t, k, m),
                rx_valid[m], 1);
            chk($sformatf("r%0d_b%0d_dat%0d", t, k, m),
                rx_data[m], last[m]);
            chk($sformatf("r%0d_b%0d_cnt%0d", t, k, m),
                byte_cnt[m], cnt[m]);
            act[m] = !nk;
          end else begin
            chk($sformatf("r%0d_b%0d_nrq%0d", t, k, m),
                ack_req[m], 0);
          end
          held[m] = held[m] && !r;
        end
        ack_pulse();
      end
    end
    if ($urandom_range(0, 1) == 1) begin
      do_stop();
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("r%0d_stop%0d", t, m),
            stop_o[m], act[m]);
        chk($sformatf("r%0d_idle%0d", t, m),
            busy[m], 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; scl_i = 1'b1;
    rd_ld = 1'b0; rd_data = 1'b0;
    rd_get_start = 1'b0; rd_get_stop = 1'b0;
    rd_bus_err = 1'b0; rd_finish = 1'b0;
    ack_done = 1'b0; tx_done = 1'b0;
    rx_ready = 1'b1;
    last[0] = 8'h00; last[1] = 8'h00;

    tbl[0] = '{8'hA0, 8'h3C, 8'hFF, 1'b1, 1'b1, 1'b1,
               1'b0, 8'hFF, 8'd2, 1'b0, 1'b1};
    tbl[1] = '{8'hA2, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0,
               1'b0, 8'h00, 8'd0, 1'b0, 1'b0};
    tbl[2] = '{8'hA0, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b1,
               1'b1, 8'h55, 8'd1, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h01, 8'h02, 1'b1, 1'b1, GC,
               1'b0, 8'h02, 8'd2, 1'b0, GC};
    tbl[4] = '{8'hA0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b1,
               1'b0, 8'h7F, 8'd2, 1'b0, 1'b1};

    cyc(3);
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk("idle_rd_en", rd_en, 2'b11);
    chk("idle_busy", busy, 2'b00);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Master read, tx handoff, repeated START
    do_start();
    send_byte(8'hA1);
    chk("rd_ack_req", ack_req[0], 1);
    chk("rd_ack_val", ack_val[0], 0);
    ack_pulse();
    chk("tx_req_on", tx_req[0], 1);
    cyc(3);
    chk("tx_req_hold", tx_req[0], 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("tx_req_off", tx_req[0], 0);
    chk("tx_wait_busy", busy[0], 1);
    rd_get_start = 1'b1;
    scl_i = 1'b1;
    tick();
    rd_get_start = 1'b0;
    chk("sync_rd_en", rd_en[0], 0);
    tick();
    chk("sync_hold", rd_en[0], 0);
    scl_i = 1'b0;
    tick();
    chk("addr_rd_en", rd_en[0], 1);
    send_byte(8'hA0);
    chk("rs_ack", ack_req[0], 1);
    chk("rs_rd_en_off", rd_en[0], 0);
    ack_pulse();
    chk("ack_fall", ack_req[0], 0);
    chk("ack_rd_en", rd_en[0], 1);
    do_stop();
    chk("rs_stop_o", stop_o[0], 1);
    tick();
    chk("stop_pulse", stop_o[0], 0);

    // Byte limit on the MAX_BYTES=2 instance
    do_start();
    send_byte(8'hA0);
    ack_pulse();
    send_byte(8'h11);
    ack_pulse();
    send_byte(8'h22);
    chk("max_nack", ack_val[1], 1);
    chk("max_ack0", ack_val[0], 0);
    ack_pulse();
    send_byte(8'h33);
    chk("max_ignore", ack_req[1], 0);
    chk("max_cnt1", byte_cnt[1], 2);
    chk("max_run0", ack_req[0], 1);
    chk("max_data0", rx_data[0], 8'h33);
    chk("max_cnt0", byte_cnt[0], 3);
    ack_pulse();
    do_stop();
    chk("max_stop", stop_o, 2'b01);

    // Bus error in DATA
    do_start();
    send_byte(8'hA0);
    ack_pulse();
    rd_ld = 1'b1;
    rd_data = 1'b1;
    cyc(4);
    rd_ld = 1'b0;
    rd_bus_err = 1'b1;
    tick();
    rd_bus_err = 1'b0;
    chk("berr_err", err_o, 2'b11);
    chk("berr_idle", busy, 2'b00);
    tick();
    chk("berr_pulse", err_o, 2'b00);

    // Reset in DATA
    do_start();
    send_byte(8'hA0);
    ack_pulse();
    rx_ready = 1'b0;
    send_byte(8'h5A);
    chk("pre_rst_vld", rx_valid[0], 1);
    chk("pre_rst_cnt", byte_cnt[0], 1);
    rst = 1'b1;
    tick();
    chk_reset("mid");
    rst = 1'b0;
    rx_ready = 1'b1;
    tick();

    // enable=0 forces IDLE
    do_start();
    send_byte(8'hA0);
    ack_pulse();
    enable = 1'b0;
    tick();
    chk("dis_busy", busy, 2'b00);
    chk("dis_rd_en", rd_en, 2'b00);
    enable = 1'b1;
    tick();
    chk("en_rd_en", rd_en, 2'b11);

    // byte_cnt saturation
    do_start();
    send_byte(8'hA0);
    ack_pulse();
    for (int k = 1; k <= 256; k++) begin
      send_byte(8'(k));
      if (k == 1) chk("sat_first", byte_cnt[0], 1);
      if (k >= 255) begin
        chk($sformatf("sat_%0d", k), byte_cnt[0], 8'hFF);
        chk($sformatf("sat_ack_%0d", k), ack_val[0], 0);
      end
      ack_pulse();
    end
    do_stop();
    tick();

    for (int t = 0; t < 40; t++) rand_xfer(t);
    do_stop();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
